apb_req_arbiter: RTL and testbench

Shares the single APB master command port (TRANSFER/read/write/address/data) between NREQ independent requesters. It sits directly in front of the APB master inside the APB top level. It selects one pending request round-robin, holds it on the master's command inputs until the APB access phase completes (PENABLE && PREADY), and returns read data and error status to the winning requester.

---
 rtl/apb_req_arbiter_if.sv | 45 ++++
 rtl/apb_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: requester-side and APB-master-side signal bundle for
// apb_req_arbiter. The "slave" modport is the arbiter's view. The "master"
// modport is the view of the surrounding requesters plus the APB master/slave.
interface apb_req_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  // Requester side
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               busy;

  // APB master command port and completion status
  logic               m_transfer;
  logic               m_write;
  logic               m_read;
  logic [AW-1:0]      m_write_address;
  logic [AW-1:0]      m_read_address;
  logic [DW-1:0]      m_write_data;
  logic               m_penable;
  logic               m_pready;
  logic               m_pslverr;
  logic [DW-1:0]      m_read_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  m_penable, m_pready, m_pslverr, m_read_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output m_transfer, m_write, m_read, m_write_address, m_read_address, m_write_data
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output m_penable, m_pready, m_pslverr, m_read_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  m_transfer, m_write, m_read, m_write_address, m_read_address, m_write_data
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master command port between
// NREQ requesters. One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
// All outputs come from registers or from state decode, never from inputs.
// Optional feature macro: APB_ARB_TIMEOUT_EN -- when defined, a WAIT that
// lasts TIMEOUT cycles without PENABLE && PREADY is completed with an error.
module apb_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_req_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 2) begin : g_bad_params
    $error("apb_req_arbiter: NREQ must be 2..4 and TIMEOUT at least 2");
  end

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_owner;
  logic            r_write;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic [PW-1:0]   w_grant_idx;
  logic            w_grant_found;
  logic            w_complete;
  logic            w_timeout;

  // (base + offset) mod NREQ, for the round-robin scan and pointer advance
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    return PW'(sum);
  endfunction

  assign w_complete = (r_state == S_WAIT) && bus.m_penable && bus.m_pready;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // WAIT-cycle counter: cleared in ISSUE so it starts at 0 on WAIT entry
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires on the TIMEOUT-th WAIT cycle; a real completion in that cycle wins
  assign w_timeout = (r_state == S_WAIT) && !w_complete && (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Round-robin winner: first pending requester at or after rr_ptr, wrapping
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would otherwise infer a latch.
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_found && bus.req_valid[rr_index(r_rr_ptr, i)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = rr_index(r_rr_ptr, i);
      end
    end
  end

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_found) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (w_complete || w_timeout) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Command latch on grant, response capture on completion, pointer advance in DONE
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_grant_found) begin
        r_owner <= w_grant_idx;
        r_write <= bus.req_write[w_grant_idx];
        r_addr  <= bus.req_addr[w_grant_idx*AW +: AW];
        r_wdata <= bus.req_write[w_grant_idx] ? bus.req_wdata[w_grant_idx*DW +: DW] : '0;
      end
      if (w_complete) begin
        r_rdata <= r_write ? '0 : bus.m_read_out;
        r_err   <= bus.m_pslverr;
      end else if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
      if (r_state == S_DONE) begin
        r_rr_ptr <= rr_index(r_owner, 1);
      end
    end
  end

  // One-hot accept and completion pulses decoded from state and owner
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (r_state == S_ISSUE) bus.req_ready[r_owner] = 1'b1;
    if (r_state == S_DONE)  bus.rsp_valid[r_owner] = 1'b1;
  end

  assign bus.busy            = (r_state != S_IDLE);
  assign bus.m_transfer      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign bus.m_write         = bus.m_transfer && r_write;
  assign bus.m_read          = bus.m_transfer && !r_write;
  assign bus.m_write_address = r_addr;
  assign bus.m_read_address  = r_addr;
  assign bus.m_write_data    = r_wdata;
  assign bus.rsp_rdata       = r_rdata;
  assign bus.rsp_err         = r_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed, table-driven bench for apb_req_arbiter with
// NREQ=2, AW=DW=32, TIMEOUT=16. Follows APB_ARB_TIMEOUT_EN like the RTL.
module tb_apb_req_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic PCLK;
  logic PRESETn;
  int   n_checks;
  int   n_errors;

  apb_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          req;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] s_rdata;
    bit          s_err;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    bus.m_penable  = 1'b0;
    bus.m_pready   = 1'b0;
    bus.m_pslverr  = 1'b0;
    bus.m_read_out = '0;
  endtask

  task automatic set_req(input int idx, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_write[idx]          = wr;
    bus.req_addr[idx*AW +: AW]  = addr;
    bus.req_wdata[idx*DW +: DW] = wdata;
    bus.req_valid[idx]          = 1'b1;
  endtask

  // Runs one transaction from an IDLE cycle with the request already presented
  task automatic serve(input int owner, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic [31:0] s_rdata, input bit s_err,
                       input logic [31:0] exp_rdata, input bit exp_err);
    logic [31:0] exp_wd;
    exp_wd = wr ? wdata : 32'h0;
    @(posedge PCLK); #1;
    check("issue_req_ready", bus.req_ready, 128'(1 << owner));
    check("issue_cmd", {bus.m_transfer, bus.m_write, bus.m_read, bus.busy}, {1'b1, wr, !wr, 1'b1});
    check("issue_addr_data", {bus.m_write_address, bus.m_read_address, bus.m_write_data}, {addr, addr, exp_wd});
    bus.req_valid[owner] = 1'b0;
    @(posedge PCLK); #1;
    check("wait_req_ready_low", bus.req_ready, 0);
    for (int k = 0; k < waits; k++) begin
      bus.m_penable  = 1'b1;
      bus.m_pready   = 1'b0;
      bus.m_read_out = 32'hBAD0_0000 | k;
      check("wait_hold", {bus.m_transfer, bus.m_write, bus.m_read, bus.m_write_address, bus.m_write_data, bus.rsp_valid},
            {1'b1, wr, !wr, addr, exp_wd, 2'b00});
      @(posedge PCLK); #1;
    end
    bus.m_penable  = 1'b1;
    bus.m_pready   = 1'b1;
    bus.m_pslverr  = s_err;
    bus.m_read_out = s_rdata;
    check("access_hold", {bus.m_transfer, bus.m_write, bus.m_read, bus.m_read_address, bus.m_write_data, bus.rsp_valid},
          {1'b1, wr, !wr, addr, exp_wd, 2'b00});
    @(posedge PCLK); #1;
    slave_idle();
    check("done_rsp_valid", bus.rsp_valid, 128'(1 << owner));
    check("done_rsp_rdata", bus.rsp_rdata, exp_rdata);
    check("done_rsp_err", bus.rsp_err, exp_err);
    check("done_cmd_low", {bus.m_transfer, bus.m_write, bus.m_read, bus.busy, bus.req_ready}, {4'b0001, 2'b00});
    @(posedge PCLK); #1;
    check("idle_pulses_low", {bus.busy, bus.rsp_valid, bus.req_ready}, 0);
    check("idle_rsp_hold", {bus.rsp_err, bus.rsp_rdata}, {exp_err, exp_rdata});
  endtask

  // Grants a read for one requester and stops in the first WAIT cycle with PREADY low
  task automatic launch_to_wait(input int owner, input logic [31:0] addr);
    bus.req_valid = '0;
    set_req(owner, 1'b0, addr, 32'h0);
    @(posedge PCLK); #1;
    check("launch_req_ready", bus.req_ready, 128'(1 << owner));
    bus.req_valid = '0;
    @(posedge PCLK); #1;
    bus.m_penable = 1'b1;
    bus.m_pready  = 1'b0;
    check("launch_in_wait", {bus.m_transfer, bus.m_read, bus.m_read_address}, {2'b11, addr});
  endtask

  initial begin
    int rsp_seen;
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h5555_0000, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000, 1'b0};
    vecs[2] = '{0, 1'b0, 32'h0000_0030, 32'h0000_0000, 1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1};
    vecs[3] = '{1, 1'b0, 32'h0000_0044, 32'h7777_7777, 0, 32'h0123_4567, 1'b0, 32'h0123_4567, 1'b0};
    vecs[4] = '{0, 1'b1, 32'h0000_005C, 32'hFFFF_0000, 2, 32'h1111_1111, 1'b1, 32'h0000_0000, 1'b1};
    vecs[5] = '{0, 1'b0, 32'h0000_0060, 32'h0000_0000, 0, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0};

    PRESETn       = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    slave_idle();

    // Reset state
    repeat (2) @(posedge PCLK);
    #1;
    check("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.busy,
                            bus.m_transfer, bus.m_write, bus.m_read}, 0);
    check("reset_addr_data", {bus.m_write_address, bus.m_read_address, bus.m_write_data}, 0);
    #3 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("post_reset_idle", {bus.busy, bus.req_ready}, 0);

    // Contention from reset: 0 then 1, then again 0 then 1
    for (int rep = 0; rep < 2; rep++) begin
      set_req(0, 1'b0, 32'h0000_0100, 32'hFEED_0000);
      set_req(1, 1'b0, 32'h0000_0200, 32'hFEED_0001);
      serve(0, 1'b0, 32'h0000_0100, 32'hFEED_0000, 0, 32'h1111_0000 + rep, 1'b0, 32'h1111_0000 + rep, 1'b0);
      serve(1, 1'b0, 32'h0000_0200, 32'hFEED_0001, 0, 32'h2222_0000 + rep, 1'b0, 32'h2222_0000 + rep, 1'b0);
    end

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = '0;
      set_req(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      serve(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
            vecs[i].s_rdata, vecs[i].s_err, vecs[i].exp_rdata, vecs[i].exp_err);
    end

`ifdef APB_ARB_TIMEOUT_EN
    // Timeout: PREADY never comes; DONE follows exactly TIMEOUT WAIT cycles
    launch_to_wait(0, 32'h0000_0070);
    repeat (TIMEOUT - 1) @(posedge PCLK);
    #1;
    check("timeout_last_wait", {bus.m_transfer, bus.rsp_valid}, {1'b1, 2'b00});
    @(posedge PCLK); #1;
    check("timeout_rsp_valid", bus.rsp_valid, 2'b01);
    check("timeout_rsp", {bus.rsp_err, bus.rsp_rdata, bus.m_transfer}, {1'b1, 32'h0, 1'b0});
    slave_idle();
    @(posedge PCLK); #1;
    check("timeout_back_idle", bus.busy, 0);
    launch_to_wait(1, 32'h0000_0080);
`else
    // No timeout: a stalled WAIT never completes on its own
    launch_to_wait(1, 32'h0000_0080);
    rsp_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge PCLK); #1;
      if (bus.rsp_valid != 0) rsp_seen++;
    end
    check("no_timeout_rsp", rsp_seen, 0);
    check("no_timeout_still_wait", {bus.m_transfer, bus.busy}, 2'b11);
`endif

    // Reset in WAIT: asynchronous clear, no completion pulse
    #3 PRESETn = 1'b0;
    #1;
    check("async_reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.busy,
                                  bus.m_transfer, bus.m_write, bus.m_read, bus.m_read_address}, 0);
    slave_idle();
    bus.req_valid = '0;
    @(posedge PCLK); #1;
    check("reset_held_no_rsp", {bus.rsp_valid, bus.busy}, 0);
    #3 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // After reset the round-robin pointer is back at requester 0
    set_req(0, 1'b0, 32'h0000_0090, 32'h0);
    set_req(1, 1'b0, 32'h0000_00A0, 32'h0);
    serve(0, 1'b0, 32'h0000_0090, 32'h0, 0, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b0);
    bus.req_valid = '0;
    @(posedge PCLK); #1;
    check("final_idle", {bus.busy, bus.req_ready}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
